// File: rtl/isa_pkg.sv
// Shared ISA definitions: datapath defaults, ALU opcode encodings and the decoded control bundle.
package isa_pkg;

    localparam int unsigned BUS_DEFAULT = 32;
    localparam int unsigned DIR_DEFAULT = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_PASS = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic [3:0] ALUOp;
        logic       MemRead;
        logic       MemWrite;
        logic       RegWrite;
        logic       Branch;
        logic       Link;
        logic       UseRS;
        logic       UseRX;
        logic       UseRK;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/forward_mux.sv
// Per-source operand forwarding: EX result beats MEM, MEM beats WB, WB beats register-bank data.
module forward_mux #(
    parameter int unsigned BUS = 32,
    parameter int unsigned DIR = 4
) (
    input  logic           use_src,
    input  logic [DIR-1:0] src,
    input  logic [BUS-1:0] bank_data,
    input  logic           ex_fwd,
    input  logic [DIR-1:0] ex_rd,
    input  logic [BUS-1:0] alu_res,
    input  logic           mem_we,
    input  logic [DIR-1:0] mem_rd,
    input  logic [BUS-1:0] mem_data,
    input  logic           wb_we,
    input  logic [DIR-1:0] wb_rd,
    input  logic [BUS-1:0] wb_data,
    output logic [BUS-1:0] data
);

    always_comb begin
        data = bank_data;
        if (use_src) begin
            if (ex_fwd && (ex_rd == src)) begin
                data = alu_res;
            end else if (mem_we && (mem_rd == src)) begin
                data = mem_data;
            end else if (wb_we && (wb_rd == src)) begin
                data = wb_data;
            end
        end
    end

endmodule

// File: rtl/decode_execute_stage.sv
// Decode/execute pipeline register with operand forwarding, load-use bubble insertion and
// a saturating bubble counter.
module decode_execute_stage
    import isa_pkg::*;
#(
    parameter int unsigned BUS = BUS_DEFAULT,
    parameter int unsigned DIR = DIR_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instr_valid,
    input  logic [DIR-1:0] RD,
    input  logic [DIR-1:0] RS,
    input  logic [DIR-1:0] RX,
    input  logic [DIR-1:0] RK,
    input  logic [BUS-1:0] RSd,
    input  logic [BUS-1:0] RXd,
    input  logic [BUS-1:0] RKd,
    input  logic [BUS-1:0] PCi,
    input  logic [BUS-1:0] Imm,
    input  ctrl_t          ctrl,
    input  logic [BUS-1:0] alu_res,
    input  logic [DIR-1:0] mem_RD,
    input  logic           mem_WE,
    input  logic [BUS-1:0] mem_data,
    input  logic [DIR-1:0] wb_RD,
    input  logic           WE,
    input  logic [BUS-1:0] WB,
    input  logic           stall_i,
    input  logic           flush,
    output logic           stall_up,
    output logic [BUS-1:0] RSe,
    output logic [BUS-1:0] RXe,
    output logic [BUS-1:0] RKe,
    output logic [BUS-1:0] PCe,
    output logic [BUS-1:0] Imme,
    output logic [DIR-1:0] RDe,
    output ctrl_t          ctrl_e,
    output logic           valid_e,
    output logic [15:0]    bubble_count
);

    logic           ex_fwd;
    logic           hazard;
    logic [BUS-1:0] rs_fwd;
    logic [BUS-1:0] rx_fwd;
    logic [BUS-1:0] rk_fwd;
    logic [15:0]    bubble_q;

    // A load in EX has no result yet, so it must never be forwarded from alu_res.
    assign ex_fwd = valid_e & ctrl_e.RegWrite & ~ctrl_e.MemRead;

    assign hazard = valid_e & ctrl_e.MemRead & instr_valid &
                    ((ctrl.UseRS & (RDe == RS)) |
                     (ctrl.UseRX & (RDe == RX)) |
                     (ctrl.UseRK & (RDe == RK)));

    assign stall_up     = ~rst & ~flush & (stall_i | hazard);
    assign bubble_count = bubble_q;

    forward_mux #(.BUS(BUS), .DIR(DIR)) u_fwd_rs (
        .use_src   (ctrl.UseRS),
        .src       (RS),
        .bank_data (RSd),
        .ex_fwd    (ex_fwd),
        .ex_rd     (RDe),
        .alu_res   (alu_res),
        .mem_we    (mem_WE),
        .mem_rd    (mem_RD),
        .mem_data  (mem_data),
        .wb_we     (WE),
        .wb_rd     (wb_RD),
        .wb_data   (WB),
        .data      (rs_fwd)
    );

    forward_mux #(.BUS(BUS), .DIR(DIR)) u_fwd_rx (
        .use_src   (ctrl.UseRX),
        .src       (RX),
        .bank_data (RXd),
        .ex_fwd    (ex_fwd),
        .ex_rd     (RDe),
        .alu_res   (alu_res),
        .mem_we    (mem_WE),
        .mem_rd    (mem_RD),
        .mem_data  (mem_data),
        .wb_we     (WE),
        .wb_rd     (wb_RD),
        .wb_data   (WB),
        .data      (rx_fwd)
    );

    forward_mux #(.BUS(BUS), .DIR(DIR)) u_fwd_rk (
        .use_src   (ctrl.UseRK),
        .src       (RK),
        .bank_data (RKd),
        .ex_fwd    (ex_fwd),
        .ex_rd     (RDe),
        .alu_res   (alu_res),
        .mem_we    (mem_WE),
        .mem_rd    (mem_RD),
        .mem_data  (mem_data),
        .wb_we     (WE),
        .wb_rd     (wb_RD),
        .wb_data   (WB),
        .data      (rk_fwd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RSe      <= '0;
            RXe      <= '0;
            RKe      <= '0;
            PCe      <= '0;
            Imme     <= '0;
            RDe      <= '0;
            ctrl_e   <= CTRL_NOP;
            valid_e  <= 1'b0;
            bubble_q <= '0;
        end else if (flush) begin
            ctrl_e  <= CTRL_NOP;
            valid_e <= 1'b0;
        end else if (stall_i) begin
            // Downstream hold: every EX register keeps its value.
        end else if (hazard) begin
            ctrl_e  <= CTRL_NOP;
            valid_e <= 1'b0;
            if (bubble_q != 16'hFFFF) begin
                bubble_q <= bubble_q + 16'd1;
            end
        end else begin
            RSe     <= rs_fwd;
            RXe     <= rx_fwd;
            RKe     <= rk_fwd;
            PCe     <= PCi;
            Imme    <= Imm;
            RDe     <= RD;
            ctrl_e  <= instr_valid ? ctrl : CTRL_NOP;
            valid_e <= instr_valid;
        end
    end

endmodule

// File: tb/tb_decode_execute_stage.sv
// Self-checking bench: forwarding vector table with a scoreboard, then hand-written hazard,
// flush, stall, saturation and asynchronous-reset sequences.
module tb_decode_execute_stage;
    import isa_pkg::*;

    localparam int unsigned BUS = 32;
    localparam int unsigned DIR = 4;
    localparam int NVEC = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           instr_valid;
    logic [DIR-1:0] RD, RS, RX, RK;
    logic [BUS-1:0] RSd, RXd, RKd, PCi, Imm;
    ctrl_t          ctrl;
    logic [BUS-1:0] alu_res;
    logic [DIR-1:0] mem_RD;
    logic           mem_WE;
    logic [BUS-1:0] mem_data;
    logic [DIR-1:0] wb_RD;
    logic           WE;
    logic [BUS-1:0] WB;
    logic           stall_i, flush;
    logic           stall_up;
    logic [BUS-1:0] RSe, RXe, RKe, PCe, Imme;
    logic [DIR-1:0] RDe;
    ctrl_t          ctrl_e;
    logic           valid_e;
    logic [15:0]    bubble_count;

    always #5 clk = ~clk;

    decode_execute_stage #(.BUS(BUS), .DIR(DIR)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .RD           (RD),
        .RS           (RS),
        .RX           (RX),
        .RK           (RK),
        .RSd          (RSd),
        .RXd          (RXd),
        .RKd          (RKd),
        .PCi          (PCi),
        .Imm          (Imm),
        .ctrl         (ctrl),
        .alu_res      (alu_res),
        .mem_RD       (mem_RD),
        .mem_WE       (mem_WE),
        .mem_data     (mem_data),
        .wb_RD        (wb_RD),
        .WE           (WE),
        .WB           (WB),
        .stall_i      (stall_i),
        .flush        (flush),
        .stall_up     (stall_up),
        .RSe          (RSe),
        .RXe          (RXe),
        .RKe          (RKe),
        .PCe          (PCe),
        .Imme         (Imme),
        .RDe          (RDe),
        .ctrl_e       (ctrl_e),
        .valid_e      (valid_e),
        .bubble_count (bubble_count)
    );

    typedef struct {
        string      name;
        logic       iv;
        logic [3:0] rd, rs, rx, rk;
        logic [31:0] rsd, rxd, rkd;
        ctrl_t      c;
        logic [31:0] alu;
        logic       mwe;
        logic [3:0] mrd;
        logic [31:0] mdat;
        logic       wwe;
        logic [3:0] wrd;
        logic [31:0] wdat;
        logic [31:0] ers, erx, erk;
    } vec_t;

    typedef struct {
        string      name;
        logic [31:0] rse, rxe, rke, pce, imme;
        logic [3:0] rde;
        logic       ve;
        ctrl_t      ce;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb [$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic ctrl_t mk(input logic mr, input logic rw, input logic urs,
                                 input logic urx, input logic urk);
        ctrl_t c;
        c          = '0;
        c.ALUOp    = 4'(ALU_SUB);
        c.MemRead  = mr;
        c.RegWrite = rw;
        c.Link     = 1'b1;
        c.UseRS    = urs;
        c.UseRX    = urx;
        c.UseRK    = urk;
        return c;
    endfunction

    function automatic vec_t v(input string name, input logic iv, input logic [3:0] rd,
                               input logic [3:0] rs, input logic [3:0] rx, input logic [3:0] rk,
                               input logic [31:0] rsd, input logic [31:0] rxd,
                               input logic [31:0] rkd, input ctrl_t c, input logic [31:0] alu,
                               input logic mwe, input logic [3:0] mrd, input logic [31:0] mdat,
                               input logic wwe, input logic [3:0] wrd, input logic [31:0] wdat,
                               input logic [31:0] ers, input logic [31:0] erx,
                               input logic [31:0] erk);
        vec_t r;
        r.name = name; r.iv = iv; r.rd = rd; r.rs = rs; r.rx = rx; r.rk = rk;
        r.rsd = rsd; r.rxd = rxd; r.rkd = rkd; r.c = c; r.alu = alu;
        r.mwe = mwe; r.mrd = mrd; r.mdat = mdat; r.wwe = wwe; r.wrd = wrd; r.wdat = wdat;
        r.ers = ers; r.erx = erx; r.erk = erk;
        return r;
    endfunction

    task automatic idle();
        instr_valid = 1'b0;
        RD = '0; RS = '0; RX = '0; RK = '0;
        RSd = '0; RXd = '0; RKd = '0; PCi = '0; Imm = '0;
        ctrl = '0; alu_res = '0;
        mem_RD = '0; mem_WE = 1'b0; mem_data = '0;
        wb_RD = '0; WE = 1'b0; WB = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid_e"}, 32'(valid_e), 32'd0);
        chk({tag, "_ctrl_e"}, 32'(ctrl_e), 32'd0);
        chk({tag, "_RSe"}, RSe, 32'd0);
        chk({tag, "_RDe"}, 32'(RDe), 32'd0);
        chk({tag, "_PCe"}, PCe, 32'd0);
        chk({tag, "_bubble_count"}, 32'(bubble_count), 32'd0);
        chk({tag, "_stall_up"}, 32'(stall_up), 32'd0);
    endtask

    // Puts a load writing register ld_rd into EX, then presents a dependent instruction.
    task automatic make_bubble(input logic [3:0] ld_rd);
        @(negedge clk);
        idle();
        instr_valid = 1'b1; RD = ld_rd; ctrl = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        idle();
        instr_valid = 1'b1; RS = ld_rd; RD = 4'd1; ctrl = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        idle();
        rst = 1'b1;
        stall_i = 1'b1;
        flush = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        stall_i = 1'b0;

        vecs[0] = v("plain", 1, 1, 3, 4, 6, 32'h11, 32'h22, 32'h33, mk(0, 1, 1, 1, 1),
                    32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h11, 32'h22, 32'h33);
        vecs[1] = v("ex_fwd", 1, 5, 1, 2, 1, 32'h100, 32'h200, 32'h300, mk(0, 1, 1, 1, 0),
                    32'hA1, 0, 0, 32'h0, 0, 0, 32'h0, 32'hA1, 32'h200, 32'h300);
        vecs[2] = v("prio_ex", 1, 5, 5, 0, 5, 32'h55, 32'h77, 32'h99, mk(0, 0, 1, 1, 0),
                    32'hAA, 1, 5, 32'hBB, 1, 5, 32'hCC, 32'hAA, 32'h77, 32'h99);
        vecs[3] = v("prio_mem", 1, 5, 5, 0, 0, 32'h55, 32'h77, 32'h88, mk(0, 0, 1, 0, 0),
                    32'hAA, 1, 5, 32'hBB, 1, 5, 32'hCC, 32'hBB, 32'h77, 32'h88);
        vecs[4] = v("prio_wb_r0", 1, 0, 5, 0, 3, 32'h55, 32'h66, 32'h44, mk(0, 1, 1, 1, 0),
                    32'hAA, 1, 0, 32'hDD, 1, 5, 32'hCC, 32'hCC, 32'hDD, 32'h44);
        vecs[5] = v("invalid_r0", 0, 6, 0, 8, 9, 32'h0, 32'h1, 32'h2, mk(0, 1, 1, 1, 1),
                    32'h1234, 0, 0, 32'h0, 0, 0, 32'h0, 32'h1234, 32'h1, 32'h2);
        vecs[6] = v("load_issue", 1, 7, 0, 0, 0, 32'h42, 32'h43, 32'h44, mk(1, 1, 1, 1, 1),
                    32'hFFFF, 0, 0, 32'h0, 0, 0, 32'h0, 32'h42, 32'h43, 32'h44);

        for (int i = 0; i < NVEC; i++) begin
            instr_valid = vecs[i].iv;
            RD = vecs[i].rd; RS = vecs[i].rs; RX = vecs[i].rx; RK = vecs[i].rk;
            RSd = vecs[i].rsd; RXd = vecs[i].rxd; RKd = vecs[i].rkd;
            ctrl = vecs[i].c; alu_res = vecs[i].alu;
            mem_WE = vecs[i].mwe; mem_RD = vecs[i].mrd; mem_data = vecs[i].mdat;
            WE = vecs[i].wwe; wb_RD = vecs[i].wrd; WB = vecs[i].wdat;
            PCi = 32'h1000 + 32'(i) * 4;
            Imm = 32'(i) + 32'h20;
            e.name = vecs[i].name;
            e.rse = vecs[i].ers; e.rxe = vecs[i].erx; e.rke = vecs[i].erk;
            e.pce = 32'h1000 + 32'(i) * 4; e.imme = 32'(i) + 32'h20;
            e.rde = vecs[i].rd; e.ve = vecs[i].iv;
            e.ce = vecs[i].iv ? vecs[i].c : '0;
            sb.push_back(e);
            #1;
            chk({vecs[i].name, "_stall_up"}, 32'(stall_up), 32'd0);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk({e.name, "_RSe"}, RSe, e.rse);
            chk({e.name, "_RXe"}, RXe, e.rxe);
            chk({e.name, "_RKe"}, RKe, e.rke);
            chk({e.name, "_PCe"}, PCe, e.pce);
            chk({e.name, "_Imme"}, Imme, e.imme);
            chk({e.name, "_RDe"}, 32'(RDe), 32'(e.rde));
            chk({e.name, "_valid_e"}, 32'(valid_e), 32'(e.ve));
            chk({e.name, "_ctrl_e"}, 32'(ctrl_e), 32'(e.ce));
            @(negedge clk);
        end

        // Load-use on RX against the load (rd=7) now in EX.
        idle();
        instr_valid = 1'b1; RS = 4'd1; RSd = 32'h10; RX = 4'd7; RXd = 32'h70; RD = 4'd8;
        ctrl = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("lu_stall_up", 32'(stall_up), 32'd1);
        @(posedge clk);
        #1;
        chk("lu_bubble_valid", 32'(valid_e), 32'd0);
        chk("lu_bubble_ctrl", 32'(ctrl_e), 32'd0);
        chk("lu_bubble_count", 32'(bubble_count), 32'd1);
        chk("lu_stall_clears", 32'(stall_up), 32'd0);
        @(negedge clk);
        mem_WE = 1'b1; mem_RD = 4'd7; mem_data = 32'h7777;
        #1;
        chk("lu_issue_stall_up", 32'(stall_up), 32'd0);
        @(posedge clk);
        #1;
        chk("lu_issue_RXe", RXe, 32'h7777);
        chk("lu_issue_RSe", RSe, 32'h10);
        chk("lu_issue_valid", 32'(valid_e), 32'd1);
        chk("lu_issue_RDe", 32'(RDe), 32'd8);
        chk("lu_issue_count", 32'(bubble_count), 32'd1);

        // Flush overrides both a pending hazard and stall_i.
        @(negedge clk);
        idle();
        instr_valid = 1'b1; RD = 4'd9; ctrl = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        idle();
        instr_valid = 1'b1; RS = 4'd9; RD = 4'd2; ctrl = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("unused_src_no_hazard", 32'(stall_up), 32'd0);
        ctrl = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("fl_hazard_seen", 32'(stall_up), 32'd1);
        stall_i = 1'b1; flush = 1'b1;
        #1;
        chk("fl_stall_up", 32'(stall_up), 32'd0);
        @(posedge clk);
        #1;
        chk("fl_valid_e", 32'(valid_e), 32'd0);
        chk("fl_ctrl_e", 32'(ctrl_e), 32'd0);
        chk("fl_count", 32'(bubble_count), 32'd1);

        // Downstream stall holds every EX register.
        @(negedge clk);
        stall_i = 1'b0; flush = 1'b0;
        idle();
        instr_valid = 1'b1; RS = 4'd2; RSd = 32'h2222; RD = 4'd3; PCi = 32'h500;
        ctrl = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("st_load_RSe", RSe, 32'h2222);
        @(negedge clk);
        RSd = 32'h3333; RD = 4'd4; PCi = 32'h504; stall_i = 1'b1;
        #1;
        chk("st_stall_up", 32'(stall_up), 32'd1);
        @(posedge clk);
        #1;
        chk("st_hold_RSe", RSe, 32'h2222);
        chk("st_hold_RDe", 32'(RDe), 32'd3);
        chk("st_hold_PCe", PCe, 32'h500);
        chk("st_hold_valid", 32'(valid_e), 32'd1);
        @(negedge clk);
        stall_i = 1'b0;

        // Saturation: preload the counter just below the top, then insert two bubbles.
        force dut.bubble_q = 16'hFFFE;
        #1;
        release dut.bubble_q;
        make_bubble(4'd10);
        chk("sat_first", 32'(bubble_count), 32'h0000FFFF);
        chk("sat_first_valid", 32'(valid_e), 32'd0);
        make_bubble(4'd10);
        chk("sat_hold", 32'(bubble_count), 32'h0000FFFF);

        // Asynchronous reset while a load-use stall is pending.
        @(negedge clk);
        idle();
        instr_valid = 1'b1; RD = 4'd11; PCi = 32'h77; ctrl = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        idle();
        instr_valid = 1'b1; RS = 4'd11; RSd = 32'h5A; RD = 4'd12; PCi = 32'h99;
        ctrl = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("ar_stall_before", 32'(stall_up), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ar_post_valid", 32'(valid_e), 32'd1);
        chk("ar_post_RSe", RSe, 32'h5A);
        chk("ar_post_RDe", 32'(RDe), 32'd12);
        chk("ar_post_PCe", PCe, 32'h99);
        chk("ar_post_count", 32'(bubble_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
